// File: rtl/snake_vga_pkg.sv
// Shared types and screen geometry for the snake VGA renderers and the cell draw scheduler.
package snake_vga_pkg;

    localparam int SCR_W = 160;
    localparam int SCR_H = 120;
    localparam int CELL  = 4;
    localparam int GW    = SCR_W / CELL;
    localparam int GH    = SCR_H / CELL;
    localparam int CXW   = $clog2(GW);
    localparam int CYW   = $clog2(GH);

    typedef logic [2:0] colour_t;

    typedef struct packed {
        logic [CXW-1:0] cx;
        logic [CYW-1:0] cy;
        colour_t        colour;
    } cell_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam colour_t BLACK = 3'b000;
    localparam colour_t GREEN = 3'b010;
    localparam colour_t RED   = 3'b100;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   grant,
    output logic            any_req
);

    logic [IW-1:0] idx_s;

    // Scan from the far end back to ptr so the candidate nearest ptr is the last one written.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx_s   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_s   = IW'((int'(ptr) + k) % NREQ);
            grant   = req[idx_s] ? idx_s : grant;
            any_req = any_req | req[idx_s];
        end
    end

endmodule

// File: rtl/cell_draw_scheduler.sv
// Arbitrates NREQ renderers onto the single vga_adapter plot port, rasterising one CELLxCELL square per grant.
// Optional build macro CLEAR_SCREEN_EN: after reset, sweep the whole screen black before serving requests.
module cell_draw_scheduler #(
    parameter int  NREQ  = 3,
    parameter int  CELL  = snake_vga_pkg::CELL,
    parameter int  SCR_W = snake_vga_pkg::SCR_W,
    parameter int  SCR_H = snake_vga_pkg::SCR_H,
    localparam int GW    = SCR_W / CELL,
    localparam int GH    = SCR_H / CELL,
    localparam int CXW   = $clog2(GW),
    localparam int CYW   = $clog2(GH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*CXW-1:0] req_cx,
    input  logic [NREQ*CYW-1:0] req_cy,
    input  logic [NREQ*3-1:0] req_colour,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic              busy,
    output logic [7:0]        vga_x,
    output logic [6:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot
);

    import snake_vga_pkg::*;

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW  = (CELL > 1) ? $clog2(CELL) : 1;
    localparam int CSH = $clog2(CELL);

`ifdef CLEAR_SCREEN_EN
    localparam sched_state_t RST_STATE = CLEAR;
`else
    localparam sched_state_t RST_STATE = IDLE;
`endif

    sched_state_t   state_r, state_s;
    logic [PW-1:0]  px_r, px_s, py_r, py_s;
    logic [IW-1:0]  gnt_r, gnt_s, ptr_r, ptr_s;
    logic [CXW-1:0] cx_r, cx_s;
    logic [CYW-1:0] cy_r, cy_s;
    colour_t        col_r, col_s;

    logic [NREQ-1:0] ack_s;
    logic            err_s, busy_s, vplot_s;
    logic [7:0]      vx_s;
    logic [6:0]      vy_s;
    colour_t         vcol_s;

    logic [IW-1:0]   arb_grant_s;
    logic            arb_any_s;

`ifdef CLEAR_SCREEN_EN
    logic [7:0] clr_x_r, clr_x_s;
    logic [6:0] clr_y_r, clr_y_s;
`endif

    // Cell coordinates become pixel coordinates by a shift; in-range cells never overflow.
    function automatic logic [7:0] pix_x(input logic [CXW-1:0] c, input logic [PW-1:0] p);
        return (8'(c) << CSH) + 8'(p);
    endfunction

    function automatic logic [6:0] pix_y(input logic [CYW-1:0] c, input logic [PW-1:0] p);
        return (7'(c) << CSH) + 7'(p);
    endfunction

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req     (req),
        .ptr     (ptr_r),
        .grant   (arb_grant_s),
        .any_req (arb_any_s)
    );

    // Next-state, datapath and next-output logic; outputs are registered from these values.
    always_comb begin
        state_s = state_r;
        px_s    = px_r;
        py_s    = py_r;
        gnt_s   = gnt_r;
        ptr_s   = ptr_r;
        cx_s    = cx_r;
        cy_s    = cy_r;
        col_s   = col_r;
        ack_s   = '0;
        err_s   = 1'b0;
        vplot_s = 1'b0;
        vx_s    = 8'd0;
        vy_s    = 7'd0;
        vcol_s  = 3'b000;
`ifdef CLEAR_SCREEN_EN
        clr_x_s = clr_x_r;
        clr_y_s = clr_y_r;
`endif
        case (state_r)
            IDLE: begin
                if (arb_any_s) begin
                    gnt_s = arb_grant_s;
                    cx_s  = req_cx[arb_grant_s*CXW +: CXW];
                    cy_s  = req_cy[arb_grant_s*CYW +: CYW];
                    col_s = req_colour[arb_grant_s*3 +: 3];
                    if ((32'(cx_s) >= 32'(GW)) || (32'(cy_s) >= 32'(GH))) begin
                        state_s            = DONE;
                        ack_s[arb_grant_s] = 1'b1;
                        err_s              = 1'b1;
                    end else begin
                        state_s = DRAW;
                        px_s    = '0;
                        py_s    = '0;
                        vplot_s = 1'b1;
                        vx_s    = pix_x(cx_s, PW'(0));
                        vy_s    = pix_y(cy_s, PW'(0));
                        vcol_s  = col_s;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            DRAW: begin
                if ((px_r == PW'(CELL - 1)) && (py_r == PW'(CELL - 1))) begin
                    state_s      = DONE;
                    ack_s[gnt_r] = 1'b1;
                end else begin
                    if (px_r == PW'(CELL - 1)) begin
                        px_s = '0;
                        py_s = py_r + PW'(1);
                    end else begin
                        px_s = px_r + PW'(1);
                    end
                    vplot_s = 1'b1;
                    vx_s    = pix_x(cx_r, px_s);
                    vy_s    = pix_y(cy_r, py_s);
                    vcol_s  = col_r;
                end
            end
            DONE: begin
                state_s = IDLE;
                ptr_s   = (gnt_r == IW'(NREQ - 1)) ? '0 : gnt_r + IW'(1);
            end
            CLEAR: begin
`ifdef CLEAR_SCREEN_EN
                vplot_s = 1'b1;
                vx_s    = clr_x_r;
                vy_s    = clr_y_r;
                vcol_s  = BLACK;
                if ((clr_x_r == 8'(SCR_W - 1)) && (clr_y_r == 7'(SCR_H - 1))) begin
                    state_s = IDLE;
                    clr_x_s = 8'd0;
                    clr_y_s = 7'd0;
                end else if (clr_x_r == 8'(SCR_W - 1)) begin
                    clr_x_s = 8'd0;
                    clr_y_s = clr_y_r + 7'd1;
                end else begin
                    clr_x_s = clr_x_r + 8'd1;
                end
`else
                state_s = IDLE;
`endif
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // The final sweep pixel is plotted on the edge that returns to IDLE, so it still reads busy.
        busy_s = (state_s != IDLE) | vplot_s;
    end

    // FSM state, latched grant and registered port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RST_STATE;
            px_r       <= '0;
            py_r       <= '0;
            gnt_r      <= '0;
            ptr_r      <= '0;
            cx_r       <= '0;
            cy_r       <= '0;
            col_r      <= 3'b000;
            ack        <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'b000;
            vga_plot   <= 1'b0;
`ifdef CLEAR_SCREEN_EN
            clr_x_r    <= 8'd0;
            clr_y_r    <= 7'd0;
`endif
        end else begin
            state_r    <= state_s;
            px_r       <= px_s;
            py_r       <= py_s;
            gnt_r      <= gnt_s;
            ptr_r      <= ptr_s;
            cx_r       <= cx_s;
            cy_r       <= cy_s;
            col_r      <= col_s;
            ack        <= ack_s;
            err        <= err_s;
            busy       <= busy_s;
            vga_x      <= vx_s;
            vga_y      <= vy_s;
            vga_colour <= vcol_s;
            vga_plot   <= vplot_s;
`ifdef CLEAR_SCREEN_EN
            clr_x_r    <= clr_x_s;
            clr_y_r    <= clr_y_s;
`endif
        end
    end

endmodule
